prio_encoder_pipe: RTL and testbench
====================================

Name: prio_encoder_pipe

Overview:
Parametrised WIDTH-to-$clog2(WIDTH) priority encoder with a registered valid/ready output stage. It generalises the one-hot 8-to-3 encoder in four ways:
- Any input width.
- Run-time selectable priority direction.
- Explicit zero and multi-hot flags instead of a high-Z output.
- A saturating error counter for invalid codes.
It sits between request/interrupt-style bit vectors and index consumers such as arbiters and decoders.

Parameters:
WIDTH, 8, number of input lines; legal range 2..256, need not be a power of 2.
OUT_W, $clog2(WIDTH), index width; localparam, not overridable.
ERR_CNT_W, 8, width of the saturating error counter.

Ports:
clk_i  in  1  clock, rising edge.
rst_i  in  1  asynchronous, active-high reset.
valid_i  in  1  input vector valid.
ready_o  out  1  block can accept the input this cycle.
d_i  in  WIDTH  input bit vector.
msb_first_i  in  1  priority mode, sampled with d_i; 1 = highest set bit wins, 0 = lowest set bit wins.
valid_o  out  1  output holds a result.
ready_i  in  1  downstream accepts the result.
y_o  out  OUT_W  encoded index of the winning bit.
zero_o  out  1  accepted vector had no bit set.
multi_o  out  1  accepted vector had more than one bit set.
err_clr_i  in  1  synchronous clear of err_cnt_o.
err_cnt_o  out  ERR_CNT_W  count of accepted vectors with zero_o or multi_o set; saturates.

Behaviour:
- Reset (async assert; release synchronised externally): valid_o=0, y_o=0, zero_o=0, multi_o=0, err_cnt_o=0.
- ready_o = !valid_o || ready_i. This is combinational and is the only comb path from input to output.
- Accept occurs when valid_i && ready_o. On accept, at the next edge:
  - valid_o=1.
  - y_o, zero_o and multi_o are loaded from d_i and msb_first_i.
- Latency is 1 cycle. Full throughput is one result per cycle while ready_i stays high.
- Output drain occurs when valid_o && ready_i. valid_o clears at the next edge unless a new accept happens in the same cycle; then the register reloads and valid_o stays 1.
- Stall (valid_o && !ready_i): y_o, zero_o, multi_o and valid_o hold stable. d_i and valid_i are ignored.
- Encoding:
  - msb_first_i=1: y_o = index of the highest set bit.
  - msb_first_i=0: y_o = index of the lowest set bit.
  - d_i=0: y_o=0, zero_o=1, multi_o=0.
  - More than one bit set: multi_o=1 and y_o is the winning index per the mode.
  - Exactly one bit set: both flags are 0 and the result is mode-independent.
- Index range: for non-power-of-2 WIDTH, y_o never exceeds WIDTH-1.
- Error counter:
  - Increments by 1 on each accept whose result has zero_o or multi_o set.
  - Holds at 2^ERR_CNT_W-1 (no wrap).
  - err_clr_i sets it to 0 at the next edge and wins over a same-cycle increment.
  - The counter is independent of the handshake stall.
- Reset mid-transfer: a held result is discarded, valid_o drops immediately on rst_i assertion, and the counter clears.
- X on d_i is permitted while valid_i=0 or ready_o=0. Assertions check this.

Decomposition:
- Package enc_pkg:
  - prio_mode_e enum (PRIO_LSB=0, PRIO_MSB=1).
  - enc_result_t struct (idx, zero, multi), parametrised by OUT_W through a typedef in the module.
- Sub-module prio_enc_comb (WIDTH; d, msb_first -> idx, zero, multi) is purely combinational and reusable by arbiters. prio_encoder_pipe adds the register stage, handshake and counter.

Test Plan:
- Reset then d_i=8'b0000_0100, valid_i=1, ready_i=1 -> one cycle later valid_o=1, y_o=3'd2, zero_o=0, multi_o=0, err_cnt_o=0.
- d_i=8'b1001_0010 with msb_first_i=1 -> y_o=7, multi_o=1. Same vector with msb_first_i=0 -> y_o=1, multi_o=1. err_cnt_o=2 after both.
- d_i=0 accepted -> y_o=0, zero_o=1, err_cnt_o increments. With ERR_CNT_W=2, five zero vectors -> err_cnt_o saturates at 3. err_clr_i asserted with a sixth zero vector -> err_cnt_o=0.
- ready_i=0 for 4 cycles with valid_i=1 and changing d_i -> ready_o=0 after the first accept, y_o holds the first result. ready_i=1 -> back-to-back results, one per cycle, no loss or duplication.
- WIDTH=5: d_i=5'b10000 in MSB mode -> y_o=3'd4. Random sweep shows y_o never exceeds 4 and matches the reference model.
- Assert rst_i while valid_o=1 and stalled -> valid_o=0 and err_cnt_o=0 in the same cycle, no output transfer after release.

Source files
------------

// File: rtl/enc_pkg.sv
// Shared types for the priority-encoder family (comb core and pipelined wrapper).
package enc_pkg;

    // Priority direction: which set bit wins when several are set.
    typedef enum logic {
        PRIO_LSB = 1'b0,
        PRIO_MSB = 1'b1
    } prio_mode_e;

    // Default geometry of the pipelined encoder.
    localparam int DEF_WIDTH     = 8;
    localparam int DEF_ERR_CNT_W = 8;

endpackage : enc_pkg

// File: rtl/prio_enc_comb.sv
// Purely combinational WIDTH-to-index priority encoder with zero/multi-hot flags.
// Reusable by arbiters; no state, no clock.
module prio_enc_comb
    import enc_pkg::*;
#(
    parameter  int WIDTH = 8,
    localparam int OUT_W = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0] d,
    input  logic             msb_first,
    output logic [OUT_W-1:0] idx,
    output logic             zero,
    output logic             multi
);

    prio_mode_e       w_mode;
    logic [OUT_W-1:0] w_lsb;
    logic [OUT_W-1:0] w_msb;
    logic             w_found;
    logic             w_multi;

    assign w_mode = prio_mode_e'(msb_first);

    // Single upward scan: first set bit is the LSB winner, last set bit is the MSB winner.
    always_comb begin
        w_lsb   = '0;
        w_msb   = '0;
        w_found = 1'b0;
        w_multi = 1'b0;
        for (int i = 0; i < WIDTH; i++) begin
            w_multi = w_multi | (d[i] & w_found);
            w_lsb   = (d[i] && !w_found) ? OUT_W'(i) : w_lsb;
            w_msb   = d[i] ? OUT_W'(i) : w_msb;
            w_found = w_found | d[i];
        end
    end

    // Both candidates are zero for an all-zero vector, so idx is 0 in that case.
    assign idx   = (w_mode == PRIO_MSB) ? w_msb : w_lsb;
    assign zero  = ~w_found;
    assign multi = w_multi;

endmodule : prio_enc_comb

// File: rtl/prio_encoder_pipe_chk.sv
// Protocol checks for prio_encoder_pipe: known data on accept, stable output while stalled.
module prio_encoder_pipe_chk #(
    parameter int WIDTH = 8,
    parameter int OUT_W = 3
) (
    input logic             clk_i,
    input logic             rst_i,
    input logic             valid_i,
    input logic             ready_o,
    input logic [WIDTH-1:0] d_i,
    input logic             msb_first_i,
    input logic             valid_o,
    input logic             ready_i,
    input logic [OUT_W-1:0] y_o,
    input logic             zero_o,
    input logic             multi_o
);

    // Data and mode must be fully known whenever they are actually captured.
    a_known_on_accept : assert property (@(posedge clk_i) disable iff (rst_i)
        (valid_i && ready_o) |-> !$isunknown({d_i, msb_first_i}));

    // A held result must not change until downstream takes it.
    a_stall_stable : assert property (@(posedge clk_i) disable iff (rst_i)
        (valid_o && !ready_i) |=> (valid_o && $stable(y_o) && $stable(zero_o) && $stable(multi_o)));

endmodule : prio_encoder_pipe_chk

// File: rtl/prio_encoder_pipe.sv
// Priority encoder with a registered valid/ready output stage and a saturating
// counter of accepted vectors that were zero or multi-hot.
module prio_encoder_pipe
    import enc_pkg::*;
#(
    parameter  int WIDTH     = DEF_WIDTH,
    parameter  int ERR_CNT_W = DEF_ERR_CNT_W,
    localparam int OUT_W     = $clog2(WIDTH)
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 valid_i,
    output logic                 ready_o,
    input  logic [WIDTH-1:0]     d_i,
    input  logic                 msb_first_i,
    output logic                 valid_o,
    input  logic                 ready_i,
    output logic [OUT_W-1:0]     y_o,
    output logic                 zero_o,
    output logic                 multi_o,
    input  logic                 err_clr_i,
    output logic [ERR_CNT_W-1:0] err_cnt_o
);

    typedef struct packed {
        logic [OUT_W-1:0] idx;
        logic             zero;
        logic             multi;
    } enc_result_t;

    localparam logic [ERR_CNT_W-1:0] CNT_MAX = {ERR_CNT_W{1'b1}};

    enc_result_t          w_res;
    enc_result_t          r_res;
    logic                 r_valid;
    logic [ERR_CNT_W-1:0] r_err_cnt;
    logic                 w_accept;
    logic                 w_bad;

    prio_enc_comb #(
        .WIDTH (WIDTH)
    ) u_enc (
        .d         (d_i),
        .msb_first (msb_first_i),
        .idx       (w_res.idx),
        .zero      (w_res.zero),
        .multi     (w_res.multi)
    );

    // The output register can take a new vector when empty or being drained now.
    assign ready_o  = !r_valid || ready_i;
    assign w_accept = valid_i && ready_o;
    assign w_bad    = w_res.zero || w_res.multi;

    // Output stage: load on accept, clear on drain without refill, hold on stall.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_valid <= 1'b0;
            r_res   <= '0;
        end else if (w_accept) begin
            r_valid <= 1'b1;
            r_res   <= w_res;
        end else if (ready_i) begin
            r_valid <= 1'b0;
        end else begin
            r_valid <= r_valid;
        end
    end

    // Error counter: clear has priority, otherwise saturating increment on bad accepts.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_err_cnt <= '0;
        end else if (err_clr_i) begin
            r_err_cnt <= '0;
        end else if (w_accept && w_bad && (r_err_cnt != CNT_MAX)) begin
            r_err_cnt <= r_err_cnt + ERR_CNT_W'(1);
        end else begin
            r_err_cnt <= r_err_cnt;
        end
    end

    assign valid_o   = r_valid;
    assign y_o       = r_res.idx;
    assign zero_o    = r_res.zero;
    assign multi_o   = r_res.multi;
    assign err_cnt_o = r_err_cnt;

    prio_encoder_pipe_chk #(
        .WIDTH (WIDTH),
        .OUT_W (OUT_W)
    ) u_chk (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .valid_i     (valid_i),
        .ready_o     (ready_o),
        .d_i         (d_i),
        .msb_first_i (msb_first_i),
        .valid_o     (valid_o),
        .ready_i     (ready_i),
        .y_o         (y_o),
        .zero_o      (zero_o),
        .multi_o     (multi_o)
    );

endmodule : prio_encoder_pipe

// File: tb/tb_prio_encoder_pipe.sv
// Bench for prio_encoder_pipe: instance A (WIDTH=8, 8-bit counter) and
// instance B (WIDTH=5, 2-bit counter) against a behavioural reference model.
module tb_prio_encoder_pipe;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic       a_valid = 1'b0, a_msb = 1'b1, a_rdy = 1'b1, a_clr = 1'b0;
    logic [7:0] a_d = 8'h00;
    logic       a_ready_o, a_valid_o, a_zero, a_multi;
    logic [2:0] a_y;
    logic [7:0] a_cnt;

    logic       b_valid = 1'b0, b_msb = 1'b1, b_rdy = 1'b1, b_clr = 1'b0;
    logic [4:0] b_d = 5'h00;
    logic       b_ready_o, b_valid_o, b_zero, b_multi;
    logic [2:0] b_y;
    logic [1:0] b_cnt;

    int checks = 0;
    int errors = 0;

    // Reference state per instance: 0 = A, 1 = B.
    int m_valid[2], m_y[2], m_zero[2], m_multi[2], m_cnt[2];

    always #5 clk = ~clk;

    prio_encoder_pipe #(.WIDTH(8), .ERR_CNT_W(8)) u_dut_a (
        .clk_i(clk), .rst_i(rst), .valid_i(a_valid), .ready_o(a_ready_o),
        .d_i(a_d), .msb_first_i(a_msb), .valid_o(a_valid_o), .ready_i(a_rdy),
        .y_o(a_y), .zero_o(a_zero), .multi_o(a_multi),
        .err_clr_i(a_clr), .err_cnt_o(a_cnt)
    );

    prio_encoder_pipe #(.WIDTH(5), .ERR_CNT_W(2)) u_dut_b (
        .clk_i(clk), .rst_i(rst), .valid_i(b_valid), .ready_o(b_ready_o),
        .d_i(b_d), .msb_first_i(b_msb), .valid_o(b_valid_o), .ready_i(b_rdy),
        .y_o(b_y), .zero_o(b_zero), .multi_o(b_multi),
        .err_clr_i(b_clr), .err_cnt_o(b_cnt)
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // One clock of the reference: count set bits, pick lowest/highest, apply handshake.
    task automatic model_step(input int k, input logic vi, input logic [255:0] d, input int w,
                              input logic msb, input logic ri, input logic clr, input int cmax);
        bit acc;
        int n, lo, hi;
        acc = vi && ((m_valid[k] == 0) || ri);
        n = $countones(d);
        lo = -1;
        hi = 0;
        for (int i = 0; i < w; i++) begin
            if (d[i]) begin
                if (lo < 0) lo = i;
                hi = i;
            end
        end
        if (clr) m_cnt[k] = 0;
        else if (acc && (n != 1) && (m_cnt[k] < cmax)) m_cnt[k] = m_cnt[k] + 1;
        if (acc) begin
            m_valid[k] = 1;
            m_y[k]     = (n == 0) ? 0 : (msb ? hi : lo);
            m_zero[k]  = (n == 0) ? 1 : 0;
            m_multi[k] = (n > 1) ? 1 : 0;
        end else if (ri) begin
            m_valid[k] = 0;
        end
    endtask

    // Reference model advances on the same edges as the DUTs.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < 2; k++) begin
                m_valid[k] = 0; m_y[k] = 0; m_zero[k] = 0; m_multi[k] = 0; m_cnt[k] = 0;
            end
        end else begin
            model_step(0, a_valid, {248'b0, a_d}, 8, a_msb, a_rdy, a_clr, 255);
            model_step(1, b_valid, {251'b0, b_d}, 5, b_msb, b_rdy, b_clr, 3);
        end
    end

    // Compare every cycle on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (!rst) begin
            chk("a_valid", a_valid_o, m_valid[0]);
            chk("a_ready", a_ready_o, ((m_valid[0] == 0) || a_rdy) ? 1 : 0);
            chk("a_cnt", a_cnt, m_cnt[0]);
            if (m_valid[0] != 0) begin
                chk("a_y", a_y, m_y[0]);
                chk("a_zero", a_zero, m_zero[0]);
                chk("a_multi", a_multi, m_multi[0]);
            end
            chk("b_valid", b_valid_o, m_valid[1]);
            chk("b_ready", b_ready_o, ((m_valid[1] == 0) || b_rdy) ? 1 : 0);
            chk("b_cnt", b_cnt, m_cnt[1]);
            if (m_valid[1] != 0) begin
                chk("b_y", b_y, m_y[1]);
                chk("b_zero", b_zero, m_zero[1]);
                chk("b_multi", b_multi, m_multi[1]);
                chk("b_y_range", (int'(b_y) <= 4) ? 1 : 0, 1);
            end
        end
    end

    task automatic a_step(input logic v, input logic [7:0] d, input logic m,
                          input logic r, input logic c);
        a_valid = v; a_d = d; a_msb = m; a_rdy = r; a_clr = c;
        @(posedge clk);
        #1;
    endtask

    task automatic b_step(input logic v, input logic [4:0] d, input logic m,
                          input logic r, input logic c);
        b_valid = v; b_d = d; b_msb = m; b_rdy = r; b_clr = c;
        @(posedge clk);
        #1;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        // Reset state
        chk("rst_valid", a_valid_o, 0);
        chk("rst_y", a_y, 0);
        chk("rst_zero", a_zero, 0);
        chk("rst_multi", a_multi, 0);
        chk("rst_cnt", a_cnt, 0);
        chk("rst_ready", a_ready_o, 1);

        // One-hot, then multi-hot in both modes, then zero
        a_step(1'b1, 8'b0000_0100, 1'b1, 1'b1, 1'b0);
        chk("onehot_valid", a_valid_o, 1);
        chk("onehot_y", a_y, 2);
        chk("onehot_flags", {a_zero, a_multi}, 0);
        chk("onehot_cnt", a_cnt, 0);
        a_step(1'b1, 8'b1001_0010, 1'b1, 1'b1, 1'b0);
        chk("msb_y", a_y, 7);
        chk("msb_multi", a_multi, 1);
        a_step(1'b1, 8'b1001_0010, 1'b0, 1'b1, 1'b0);
        chk("lsb_y", a_y, 1);
        chk("lsb_multi", a_multi, 1);
        chk("multi_cnt", a_cnt, 2);
        a_step(1'b1, 8'h00, 1'b1, 1'b1, 1'b0);
        chk("zero_y", a_y, 0);
        chk("zero_flag", a_zero, 1);
        chk("zero_cnt", a_cnt, 3);
        a_step(1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
        chk("drain_valid", a_valid_o, 0);

        // Stall: first vector held for 4 cycles while the input keeps changing
        a_step(1'b1, 8'h08, 1'b1, 1'b0, 1'b0);
        chk("stall_first_y", a_y, 3);
        for (int k = 0; k < 4; k++) begin
            a_step(1'b1, 8'h80 >> k, 1'b1, 1'b0, 1'b0);
            chk("stall_ready", a_ready_o, 0);
            chk("stall_y", a_y, 3);
            chk("stall_valid", a_valid_o, 1);
        end
        a_step(1'b1, 8'h10, 1'b1, 1'b1, 1'b0);
        chk("b2b_y0", a_y, 4);
        a_step(1'b1, 8'h20, 1'b1, 1'b1, 1'b0);
        chk("b2b_y1", a_y, 5);
        a_step(1'b1, 8'h40, 1'b1, 1'b1, 1'b0);
        chk("b2b_y2", a_y, 6);
        a_step(1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
        chk("b2b_end_valid", a_valid_o, 0);
        chk("b2b_cnt", a_cnt, 3);

        // Clear wins over a same-cycle increment
        a_step(1'b1, 8'h00, 1'b1, 1'b1, 1'b1);
        chk("clr_cnt", a_cnt, 0);
        a_step(1'b1, 8'h00, 1'b1, 1'b1, 1'b0);
        chk("after_clr_cnt", a_cnt, 1);

        // Instance B: WIDTH=5 index range and 2-bit saturation
        b_step(1'b1, 5'b10000, 1'b1, 1'b1, 1'b0);
        chk("w5_msb_y", b_y, 4);
        for (int k = 0; k < 5; k++) begin
            b_step(1'b1, 5'b00000, 1'b1, 1'b1, 1'b0);
            chk("sat_cnt", b_cnt, (k < 3) ? k + 1 : 3);
        end
        b_step(1'b1, 5'b00000, 1'b1, 1'b1, 1'b1);
        chk("sat_clr_cnt", b_cnt, 0);
        for (int v = 0; v < 32; v++) begin
            for (int m = 0; m < 2; m++) begin
                b_step(1'b1, 5'(v), m[0], 1'b1, 1'b0);
            end
        end
        b_step(1'b0, 5'b00000, 1'b1, 1'b1, 1'b0);

        // Reset while a result is stalled
        a_step(1'b1, 8'h03, 1'b0, 1'b1, 1'b0);
        a_step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        chk("pre_rst_valid", a_valid_o, 1);
        rst = 1'b1;
        #1;
        chk("mid_rst_valid", a_valid_o, 0);
        chk("mid_rst_cnt", a_cnt, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        a_step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        chk("post_rst_valid0", a_valid_o, 0);
        a_step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        chk("post_rst_valid1", a_valid_o, 0);

        repeat (2) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_prio_encoder_pipe
